// File: rtl/ring_buffer_reader_pkg.sv
// ============================================================================
// ring_buffer_reader_pkg : shared types and width helpers for the ring reader
// Revision: 1.0
// ============================================================================
`default_nettype none

package ring_buffer_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  localparam int unsigned ENTRIES_DEFAULT    = 2048;
  localparam int unsigned WINDOW_MAX_DEFAULT = 2048;

  // Bits needed to hold any value in 0..max_val inclusive.
  function automatic int unsigned count_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int unsigned OCC_W_DEFAULT = count_width(ENTRIES_DEFAULT);
  localparam int unsigned LEN_W_DEFAULT = count_width(WINDOW_MAX_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// sample_fifo : synchronous register FIFO, registered head, no fall-through
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [DATA_WIDTH-1:0]               push_data,
  input  logic                                pop,
  output logic [DATA_WIDTH-1:0]               head,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A pop on an empty FIFO is dropped, so a same-cycle push only shows next cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ring_buffer_reader.sv
// ============================================================================
// ring_buffer_reader : paced window reader for the audio sample ring buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module ring_buffer_reader
  import ring_buffer_reader_pkg::*;
#(
  parameter int unsigned ENTRIES    = 2048,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WINDOW_MAX = 2048,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 shift_trigger_in,
  input  logic                                 start_in,
  input  logic [$clog2(WINDOW_MAX+1)-1:0]      window_len_in,
  output logic                                 read_trigger_out,
  input  logic [DATA_WIDTH-1:0]                rb_data_in,
  input  logic                                 rb_valid_in,
  output logic [DATA_WIDTH-1:0]                sample_out,
  output logic                                 sample_valid_out,
  input  logic                                 sample_ready_in,
  output logic                                 sample_last_out,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic                                 overrun_out,
  output logic [$clog2(ENTRIES+1)-1:0]         occupancy_out
);

  localparam int unsigned OCC_W  = count_width(ENTRIES);
  localparam int unsigned LEN_W  = count_width(WINDOW_MAX);
  localparam int unsigned FCNT_W = count_width(FIFO_DEPTH);

  reader_state_t         r_state;
  reader_state_t         w_state_next;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_overrun;
  logic [LEN_W-1:0]      r_issue_cnt;
  logic [LEN_W-1:0]      r_recv_cnt;
  logic                  r_inflight;
  logic                  r_done;
  logic                  w_read;
  logic                  w_busy;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit_ok;
  logic                  w_last_accept;
  logic                  w_start_win;
  logic                  w_start_empty;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FCNT_W-1:0]     w_fifo_count;
  logic [DATA_WIDTH-1:0] w_head;

  // Only data we asked for is captured; a stale valid right after reset is dropped.
  assign w_push        = rb_valid_in & r_inflight;
  assign w_pop         = ~w_fifo_empty & sample_ready_in;
  assign w_credit_ok   = r_inflight ? (w_fifo_count < FCNT_W'(FIFO_DEPTH - 1))
                                    : (w_fifo_count < FCNT_W'(FIFO_DEPTH));
  assign w_last_accept = w_pop & w_busy & (r_recv_cnt == LEN_W'(1));
  assign w_start_win   = (r_state == IDLE) & start_in & (window_len_in != '0);
  assign w_start_empty = (r_state == IDLE) & start_in & (window_len_in == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_win) w_state_next = READ;
      READ:    if (w_read && (r_issue_cnt == LEN_W'(1))) w_state_next = DRAIN;
      DRAIN:   if (w_last_accept) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
    w_read = (r_state == READ) & (r_issue_cnt != '0) & (r_occ != '0) & w_credit_ok;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_start_empty | w_last_accept;
      if (w_start_win) begin
        r_issue_cnt <= window_len_in;
        r_recv_cnt  <= window_len_in;
      end else begin
        if (w_read) begin
          r_issue_cnt <= r_issue_cnt - LEN_W'(1);
        end
        if (w_pop && w_busy) begin
          r_recv_cnt <= r_recv_cnt - LEN_W'(1);
        end
      end
      if (w_read) begin
        r_inflight <= 1'b1;
      end else if (rb_valid_in) begin
        r_inflight <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_occ     <= '0;
      r_overrun <= 1'b0;
    end else begin
      case ({shift_trigger_in, w_read})
        2'b10: begin
          if (r_occ == OCC_W'(ENTRIES)) begin
            r_overrun <= 1'b1;
          end else begin
            r_occ <= r_occ + OCC_W'(1);
          end
        end
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_sample_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (w_push),
    .push_data (rb_data_in),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign read_trigger_out = w_read;
  assign sample_valid_out = ~w_fifo_empty;
  assign sample_out       = w_fifo_empty ? '0 : w_head;
  assign sample_last_out  = ~w_fifo_empty & w_busy & (r_recv_cnt == LEN_W'(1));
  assign busy_out         = w_busy;
  assign done_out         = r_done;
  assign overrun_out      = r_overrun;
  assign occupancy_out    = r_occ;

endmodule

`default_nettype wire

// File: doc/ring_buffer_reader.md
Name: ring_buffer_reader

Overview:
- Read-side controller for the audio sample ring buffer.
- On a start pulse it drains a window of WINDOW_MAX or fewer samples. It paces read_trigger pulses so that it never reads an empty buffer and never overflows its local output FIFO.
- It presents the samples downstream on a valid/ready stream with a last-sample marker.
- It mirrors the writer's shift_trigger to track buffer occupancy and flags overruns.

Parameters:
- ENTRIES, 2048, depth of the ring buffer being drained; occupancy counter range 0..ENTRIES.
- DATA_WIDTH, 32, sample width.
- WINDOW_MAX, 2048, largest window length accepted.
- FIFO_DEPTH, 4, local output FIFO entries; must be a power of two and at least 2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- shift_trigger_in  input  1  copy of the writer's shift_trigger, one pulse per sample written
- start_in  input  1  single-cycle pulse to begin a window; ignored while busy_out=1
- window_len_in  input  $clog2(WINDOW_MAX+1)  samples to read; sampled on start_in
- read_trigger_out  output  1  drives the ring buffer read_trigger
- rb_data_in  input  DATA_WIDTH  ring buffer data_out
- rb_valid_in  input  1  ring buffer data_valid_out
- sample_out  output  DATA_WIDTH  downstream sample
- sample_valid_out  output  1  sample_out valid
- sample_ready_in  input  1  downstream accepts when valid and ready are both high
- sample_last_out  output  1  high with the final sample of the window
- busy_out  output  1  window in progress
- done_out  output  1  one-cycle pulse when the last sample is accepted
- overrun_out  output  1  sticky: the writer lapped unread data
- occupancy_out  output  $clog2(ENTRIES+1)  unread samples in the ring buffer

Behaviour:
- Reset state: all outputs 0, occupancy 0, FIFO empty, state IDLE, overrun cleared.
- Reset mid-window aborts the window with no done_out. Any in-flight rb_valid_in on the cycle after reset is discarded.
- Occupancy counter:
  - +1 on shift_trigger_in, -1 on read_trigger_out; both in the same cycle leaves it unchanged.
  - On shift_trigger_in with occupancy==ENTRIES and no read: the count holds at ENTRIES and overrun_out sets.
  - overrun_out clears only on reset.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: on start_in with window_len_in != 0, latch len into issue_cnt and recv_cnt and go to READ.
  - IDLE, start_in with len 0: done_out pulses the next cycle; stay IDLE.
  - READ: read_trigger_out=1 only when issue_cnt>0, occupancy>0, and (FIFO count + in-flight) < FIFO_DEPTH. Each pulse decrements issue_cnt. When issue_cnt reaches 0, go to DRAIN.
  - DRAIN: when the last sample is accepted downstream, pulse done_out and go to IDLE.
  - busy_out=1 in READ and DRAIN.
- In-flight tracking:
  - Ring buffer latency is 1 cycle: rb_valid_in is asserted the cycle after read_trigger_out.
  - In-flight is 1 bit, set on read_trigger_out and cleared on rb_valid_in.
  - Back-to-back triggers are allowed, so at most 1 is outstanding per cycle of latency.
- Capture: rb_data_in is pushed into the FIFO on rb_valid_in. The credit rule guarantees the push never finds the FIFO full.
- Window count: recv_cnt decrements on each downstream handshake. sample_last_out is asserted while sample_valid_out=1 and recv_cnt==1.
- Output stream:
  - FIFO head drives sample_out/sample_valid_out.
  - Once sample_valid_out is asserted it must remain asserted, with sample_out stable, until accepted.
  - Push and pop in the same cycle with the FIFO full or empty are both legal; for an empty FIFO the push lands and valid rises the next cycle (no bypass).
- Throughput: 1 sample/clk sustained while occupancy>0 and sample_ready_in=1.
- Empty buffer mid-window: reads stall without timeout; the window resumes when shift_trigger_in arrives.
- Wrap-around is handled by the ring buffer; this block only counts.

Decomposition:
- Package ring_buffer_reader_pkg: reader_state_t enum {IDLE, READ, DRAIN}; localparams for counter widths derived from ENTRIES and WINDOW_MAX.
- Sub-module sample_fifo (DATA_WIDTH, FIFO_DEPTH): synchronous register FIFO with push, pop, full, empty, and count; no fall-through.

Test Plan:
- Basic window: shift 8 samples 1..8, start with len=4, ready=1 -> read_trigger_out high for 4 consecutive cycles; sample_out 1,2,3,4; last with 4; done_out pulses once; occupancy_out 8->4.
- Empty stall: occupancy 0, start len=3, then one shift every 5 cycles with data 10,11,12 -> exactly one trigger follows each shift; outputs 10,11,12; read_trigger_out never high at occupancy 0.
- Backpressure: occupancy 16, len=10, sample_ready_in low for 20 cycles -> at most FIFO_DEPTH triggers issued, sample_out held stable; after ready rises, all 10 delivered in order with no loss or duplicate.
- Simultaneous shift and read at occupancy 1 -> occupancy stays 1. Shift at occupancy==ENTRIES with no read -> occupancy stays ENTRIES and overrun_out=1 until reset.
- Reset mid-window after 2 of 6 samples delivered -> all outputs 0 the next cycle, no done_out. A new start with len=2 works normally.
- Edge starts: start with len=0 -> done_out pulses and busy_out never rises. start_in while busy -> ignored, with the current window count unchanged.
